opposite_cnt_array: RTL and testbench
=====================================

// Module: opposite_cnt_array
// PURPOSE
// - NCH independent counter lanes; each holds explicit count v (ILA-modelled) and implicit
//   shadow imp (micro-arch, not modelled); invariant per lane: v == MAX - imp, MAX = 2**WIDTH-1.
// - Successor to the single 4-bit opposite counter: width/lane parametrised, up/down/load ops,
//   wrap or saturate mode, two-phase load with transient invariant break. Invariant-synthesis target.
// PARAMETERS
// - WIDTH     4  lane counter width in bits
// - NCH       2  number of lanes (>=1)
// - SATURATE  0  0: INC/DEC wrap modulo 2**WIDTH; 1: clamp at MAX/0
// PORTS
// - clk        in   1            single clock, all state on posedge
// - rst        in   1            synchronous, active-high reset
// - cmd_valid  in   1            command present
// - cmd_ready  out  1            command accepted on cycles with cmd_valid && cmd_ready
// - cmd_op     in   2            00 NOP, 01 INC, 10 DEC, 11 LOAD
// - cmd_ch     in   CW           target lane, CW = max(1,$clog2(NCH)); values >= NCH are NOP
// - cmd_data   in   WIDTH        LOAD value
// - ovf_clr    in   1            clears all sticky ovf bits
// - out        out  NCH*WIDTH    lane i at [i*WIDTH +: WIDTH]; registered v & (MAX - imp)
// - ovf        out  NCH          sticky per-lane wrap/saturate flag
// - inv_ok     out  1            combinational: all lanes satisfy v == MAX - imp
// BEHAVIOUR
// - Reset: v=0, imp=MAX, out=0, ovf=0, load-pending=0 on every lane; cmd_ready=0 while rst high.
// - cmd_ready = !rst && !pending. Only one command per cycle; non-selected lanes hold.
// - INC (accept edge): v<=v+1, imp<=imp-1 same edge. At v==MAX: wrap v=0/imp=MAX (SATURATE=0)
//   or hold (SATURATE=1); either way ovf[ch]<=1.
// - DEC: v<=v-1, imp<=imp+1. At v==0: wrap v=MAX/imp=0 or hold; ovf[ch]<=1.
// - LOAD, two phases: accept edge v<=cmd_data, latch ch, pending<=1; next edge imp<=MAX-cmd_data
//   (latched), pending<=0. cmd_ready low for exactly that one intervening cycle.
// - Between phases inv_ok may be 0 (it is 1 iff latched data equals previous v); at all other
//   times inv_ok==1.
// - out lane i updates each edge to v_i & (MAX - imp_i) using pre-edge values (1-cycle latency
//   after the state edge), except it holds while lane i has a load pending; hence out lane i
//   always equals a value that v_i held with the invariant intact.
// - ovf_clr: clears ovf on the edge; if same edge sets a lane's ovf, set wins for that lane.
// - Reset mid-load: pending dropped, all lanes to reset values; no half-applied load survives.
// - Arithmetic strictly modulo 2**WIDTH; no width extension leaks into out.
// STRUCTURE
// - opposite_cnt_pkg: op encoding typedef (OP_NOP/INC/DEC/LOAD), function cnt_max(WIDTH).
// - opposite_cnt_lane: one lane (v, imp, out reg, ovf, phase-2 imp write); top instantiates NCH
//   lanes via generate, owns cmd decode, pending flag, latched ch/data, cmd_ready, inv_ok.
// TESTING (WIDTH=4, NCH=2 unless noted)
// - Reset then 5x INC ch0 -> v0=5, imp0=10, out lane0=5 one cycle after last accept, inv_ok=1 always.
// - LOAD ch1 data=9 -> cmd_ready=0 next cycle, inv_ok=0 that cycle, imp1=6 after; out lane1
//   holds 0 during pending, shows 9 one cycle after phase 2.
// - SATURATE=0: LOAD ch0 15, INC -> v0=0, imp0=15, ovf[0]=1; DEC from 0 -> v0=15, ovf set.
// - SATURATE=1: v0=15 INC -> v0 stays 15, ovf[0]=1; ovf_clr with no event -> ovf=0.
// - rst asserted in LOAD phase-2 cycle -> next cycle v=0, imp=15, pending=0, cmd_ready=1 after rst.
// - Random INC/DEC/LOAD/NOP stream, cmd_ch incl. out-of-range (NCH=3, CW=2, ch=3) -> scoreboard
//   match; inv_ok==1 whenever cmd_ready==1; out lane i == v_i model delayed 1 cycle.

Source files
------------

// File: rtl/opposite_cnt_pkg.sv
// Shared op encoding and width helper for the opposite-counter lane array.
package opposite_cnt_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  function automatic int unsigned cnt_max(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/opposite_cnt_array_if.sv
// Command bus into the counter array: one op per accepted cycle, plus sticky-flag clear.
interface opposite_cnt_array_if #(
  parameter int WIDTH = 4,
  parameter int CW    = 1
);
  import opposite_cnt_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  op_e              cmd_op;
  logic [CW-1:0]    cmd_ch;
  logic [WIDTH-1:0] cmd_data;
  logic             ovf_clr;

  modport master (output cmd_valid, cmd_op, cmd_ch, cmd_data, ovf_clr, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_ch, cmd_data, ovf_clr, output cmd_ready);
endinterface

// File: rtl/opposite_cnt_lane.sv
// One counter lane: explicit count v plus shadow imp kept at MAX - v, with registered view and sticky ovf.
module opposite_cnt_lane
  import opposite_cnt_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int SATURATE = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_load,
  input  logic             i_ph2,
  input  logic             i_pend,
  input  logic             i_ovf_clr,
  input  logic [WIDTH-1:0] i_data,
  input  logic [WIDTH-1:0] i_ph2_data,
  output logic [WIDTH-1:0] o_out,
  output logic             o_ovf,
  output logic             o_inv_ok
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(cnt_max(WIDTH));

  logic [WIDTH-1:0] r_v, r_imp, r_out;
  logic             r_ovf;
  logic             w_at_max, w_at_zero, w_ovf_set;

  assign w_at_max  = (r_v == MAX);
  assign w_at_zero = (r_v == '0);
  assign w_ovf_set = (i_inc && w_at_max) || (i_dec && w_at_zero);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v   <= '0;
      r_imp <= MAX;
      r_out <= '0;
      r_ovf <= 1'b0;
    end else begin
      // Plain modular add/sub already wraps both v and imp in lockstep.
      if (i_inc) begin
        if (!((SATURATE != 0) && w_at_max)) begin
          r_v   <= r_v + 1'b1;
          r_imp <= r_imp - 1'b1;
        end
      end else if (i_dec) begin
        if (!((SATURATE != 0) && w_at_zero)) begin
          r_v   <= r_v - 1'b1;
          r_imp <= r_imp + 1'b1;
        end
      end else if (i_load) begin
        r_v <= i_data;
      end
      if (i_ph2) r_imp <= MAX - i_ph2_data;
      // Hold the view while v and imp disagree mid-load.
      if (!i_pend) r_out <= r_v & (MAX - r_imp);
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (i_ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign o_out    = r_out;
  assign o_ovf    = r_ovf;
  assign o_inv_ok = (r_v == (MAX - r_imp));
endmodule

// File: rtl/opposite_cnt_array.sv
// NCH opposite-counter lanes behind one command port; owns decode and the two-phase load sequencing.
module opposite_cnt_array
  import opposite_cnt_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int NCH      = 2,
  parameter int SATURATE = 0,
  localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  opposite_cnt_array_if.slave  cmd_if,
  output logic [NCH*WIDTH-1:0] o_out,
  output logic [NCH-1:0]       o_ovf,
  output logic                 o_inv_ok
);
  logic                       r_pend;
  logic [CW-1:0]              r_ch;
  logic [WIDTH-1:0]           r_data;
  logic                       w_acc, w_in_range;
  logic [NCH-1:0]             w_inv_ok;
  logic [NCH-1:0][WIDTH-1:0]  w_out;

  assign cmd_if.cmd_ready = !i_rst && !r_pend;
  assign w_acc            = cmd_if.cmd_valid && cmd_if.cmd_ready;
  assign w_in_range       = 32'(cmd_if.cmd_ch) < NCH;

  // Phase 2 of a load always lands on the edge right after acceptance.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend <= 1'b0;
      r_ch   <= '0;
      r_data <= '0;
    end else if (r_pend) begin
      r_pend <= 1'b0;
    end else if (w_acc && w_in_range && cmd_if.cmd_op == OP_LOAD) begin
      r_pend <= 1'b1;
      r_ch   <= cmd_if.cmd_ch;
      r_data <= cmd_if.cmd_data;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    logic w_sel, w_pend;
    assign w_sel  = w_acc && (cmd_if.cmd_ch == CW'(g));
    assign w_pend = r_pend && (r_ch == CW'(g));

    opposite_cnt_lane #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_lane (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_inc      (w_sel && cmd_if.cmd_op == OP_INC),
      .i_dec      (w_sel && cmd_if.cmd_op == OP_DEC),
      .i_load     (w_sel && cmd_if.cmd_op == OP_LOAD),
      .i_ph2      (w_pend),
      .i_pend     (w_pend),
      .i_ovf_clr  (cmd_if.ovf_clr),
      .i_data     (cmd_if.cmd_data),
      .i_ph2_data (r_data),
      .o_out      (w_out[g]),
      .o_ovf      (o_ovf[g]),
      .o_inv_ok   (w_inv_ok[g])
    );
  end

  assign o_out    = w_out;
  assign o_inv_ok = &w_inv_ok;
endmodule

// File: tb/tb_opposite_cnt_array.sv
// Wrap and saturate arrays driven by one command stream, each checked against a lane-value model.
module tb_opposite_cnt_array;
  import opposite_cnt_pkg::*;

  localparam int W = 4, N = 3, CW = 2, MX = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  opposite_cnt_array_if #(.WIDTH(W), .CW(CW)) if0 ();
  opposite_cnt_array_if #(.WIDTH(W), .CW(CW)) if1 ();

  logic [N*W-1:0] out0, out1;
  logic [N-1:0]   ovf0, ovf1;
  logic           ok0, ok1;

  opposite_cnt_array #(.WIDTH(W), .NCH(N), .SATURATE(0)) u_wrap (
    .i_clk(clk), .i_rst(rst), .cmd_if(if0.slave),
    .o_out(out0), .o_ovf(ovf0), .o_inv_ok(ok0));
  opposite_cnt_array #(.WIDTH(W), .NCH(N), .SATURATE(1)) u_sat (
    .i_clk(clk), .i_rst(rst), .cmd_if(if1.slave),
    .o_out(out1), .o_ovf(ovf1), .o_inv_ok(ok1));

  int total = 0, bad = 0;
  // Model: index 0 = wrap array, 1 = saturate array; out is "lane value one edge ago unless loading"
  int mv[2][N], movf[2][N], mout[2][N], pprev[2];
  bit mp = 1'b0;
  int pch = 0, pdata = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input bit vld, input int op, input int ch, input int data, input bit clr);
    if0.cmd_valid = vld;  if1.cmd_valid = vld;
    if0.cmd_op    = op_e'(2'(op));  if1.cmd_op = op_e'(2'(op));
    if0.cmd_ch    = CW'(ch);  if1.cmd_ch = CW'(ch);
    if0.cmd_data  = W'(data); if1.cmd_data = W'(data);
    if0.ovf_clr   = clr;  if1.ovf_clr = clr;
  endtask

  task automatic model_edge(input bit vld, input int op, input int ch, input int data,
                            input bit clr, input bit r);
    if (r) begin
      for (int d = 0; d < 2; d++)
        for (int l = 0; l < N; l++) begin mv[d][l] = 0; movf[d][l] = 0; mout[d][l] = 0; end
      mp = 1'b0;
      return;
    end
    for (int d = 0; d < 2; d++)
      for (int l = 0; l < N; l++) begin
        if (!(mp && pch == l)) mout[d][l] = mv[d][l];
        if (clr) movf[d][l] = 0;
      end
    if (mp) mp = 1'b0;
    else if (vld && ch < N) begin
      for (int d = 0; d < 2; d++) begin
        case (op)
          1: if (mv[d][ch] == MX) begin movf[d][ch] = 1; if (d == 0) mv[d][ch] = 0; end
             else mv[d][ch]++;
          2: if (mv[d][ch] == 0) begin movf[d][ch] = 1; if (d == 0) mv[d][ch] = MX; end
             else mv[d][ch]--;
          3: begin pprev[d] = mv[d][ch]; mv[d][ch] = data; end
          default: ;
        endcase
      end
      if (op == 3) begin mp = 1'b1; pch = ch; pdata = data; end
    end
  endtask

  task automatic cyc(input bit vld, input int op, input int ch, input int data,
                     input bit clr, input bit r);
    int eo, ef;
    rst = r;
    drive(vld, op, ch, data, clr);
    #1;
    chk("ready_wrap", int'(if0.cmd_ready), int'(!r && !mp));
    chk("ready_sat",  int'(if1.cmd_ready), int'(!r && !mp));
    chk("inv_wrap", int'(ok0), mp ? int'(pdata == pprev[0]) : 1);
    chk("inv_sat",  int'(ok1), mp ? int'(pdata == pprev[1]) : 1);
    model_edge(vld, op, ch, data, clr, r);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      eo = 0; ef = 0;
      for (int l = 0; l < N; l++) begin
        eo |= mout[d][l] << (W * l);
        ef |= movf[d][l] << l;
      end
      chk(d == 0 ? "out_wrap" : "out_sat", d == 0 ? int'(out0) : int'(out1), eo);
      chk(d == 0 ? "ovf_wrap" : "ovf_sat", d == 0 ? int'(ovf0) : int'(ovf1), ef);
    end
    @(negedge clk);
  endtask

  initial begin
    drive(1'b0, 0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    cyc(0, 0, 0, 0, 0, 1);                     // reset state, ready low in reset
    repeat (5) cyc(1, 1, 0, 0, 0, 0);          // 5x INC ch0
    cyc(0, 0, 0, 0, 0, 0);                     // out lane0 = 5
    cyc(1, 3, 1, 9, 0, 0);                     // LOAD ch1 9
    cyc(1, 1, 1, 0, 0, 0);                     // pending: ready 0, inv 0, cmd ignored
    cyc(0, 0, 0, 0, 0, 0);                     // lane1 shows 9
    cyc(1, 3, 0, 15, 0, 0);                    // LOAD ch0 15
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);                     // wrap -> 0 / sat holds 15
    cyc(1, 2, 0, 0, 0, 0);                     // wrap 0 -> 15 / sat 15 -> 14
    cyc(1, 1, 0, 0, 1, 0);                     // clr with same-edge set on wrap array
    cyc(0, 0, 0, 0, 1, 0);                     // clr with no event
    cyc(1, 3, 2, 3, 0, 0);                     // LOAD ch2 3 then reset in phase-2 cycle
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 1, 2, 0, 0, 0);
    cyc(1, 3, 3, 7, 0, 0);                     // out-of-range LOAD is a NOP
    cyc(1, 1, 3, 0, 0, 0);
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, MX), $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
